ppf_commutator: RTL
===================

Name: ppf_commutator

Overview:
- Input commutator directly upstream of the direct-form polyphase filter bank (ppf_top).
- Takes one serial sample stream and deserialises it into NUM_CH parallel lanes, in polyphase order.
- Presents each complete block to ppf_top as one data_valid pulse with all lanes updated together.
- An optional start-of-frame marker realigns the block boundary and discards any partial block.

Parameters:
- NUM_CH, 8, number of polyphase branches; a power of two, at least 2.
- DATA_W, 32, sample width in bits; signed two's complement.
- REVERSE_ORDER, 1, lane mapping: 1 = sample n goes to lane NUM_CH-1-n (standard PPF commutator); 0 = sample n goes to lane n.
- WAIT_SOF, 1, startup alignment: 1 = discard samples after reset until the first sof_i; 0 = start filling immediately.

Ports:
- clk_i  in  1  single clock for the whole block.
- rst_i  in  1  synchronous, active-high reset.
- sample_valid_i  in  1  sample_i and sof_i are valid this cycle.
- sample_i  in  DATA_W  serial input sample.
- sof_i  in  1  start of frame; qualified by sample_valid_i. The qualified sample becomes block index 0.
- data_valid_o  out  1  one-cycle pulse: data_o holds a new complete block. Connects to ppf_top data_valid_i.
- data_o  out  NUM_CH*DATA_W  packed lanes; lane k is bits [k*DATA_W +: DATA_W] and connects to ppf_top channelk_data_i.
- sof_err_o  out  1  one-cycle pulse: a partial block was discarded.
- aligned_o  out  1  block boundary is established (state FILL).

Behaviour:
- Reset (rst_i=1 at a clk_i edge) sets:
  - data_o = 0, data_valid_o = 0, sof_err_o = 0;
  - fill bank = 0, idx = 0;
  - state = SEEK if WAIT_SOF=1, otherwise FILL; aligned_o follows the state.
- Reset mid-block discards the partial block. No sof_err_o pulse is generated.
- States:
  - SEEK: accepted samples are dropped unless sof_i=1. A sample with sof_i=1 is stored as index 0, idx becomes 1, and the state moves to FILL.
  - FILL: each accepted sample is written to the fill-bank lane map(idx), and idx increments.
- Lane mapping: map(n) = NUM_CH-1-n if REVERSE_ORDER=1, otherwise n.
- Block completion:
  - Trigger: a sample is accepted with idx = NUM_CH-1.
  - That sample is written straight into the output path.
  - Next cycle: data_o = full bank (including the last sample), data_valid_o = 1 for exactly one cycle, idx = 0.
  - Latency is 1 clock from the last sample to data_valid_o.
- Gaps: sample_valid_i may deassert at any time. idx and the bank hold, and there is no timeout.
- Back-to-back blocks: a block may start filling in the same cycle as the previous pulse. With valid held high continuously, data_valid_o pulses once every NUM_CH cycles.
- data_o holds its value between pulses and changes only on a completion edge.
- sof_i in FILL with idx=0: normal start, no error.
- sof_i in FILL with idx≠0 (including idx=NUM_CH-1): the partial block is discarded and there is no data_valid_o pulse. The sof sample is stored as index 0, idx becomes 1, and sof_err_o pulses on the next cycle.
- sof_i=1 without sample_valid_i is ignored.
- No backpressure: ppf_top has no ready, so every valid sample is accepted.
- Arithmetic: no arithmetic on sample data; bits pass through unchanged. idx width is $clog2(NUM_CH) and wraps modulo NUM_CH.

Optional Feature:
- Macro: PPF_COMMUTATOR_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt_o (16 bits).
  - Increments on every discarded partial block (each sof_err_o event) and on every sample dropped in SEEK.
  - Saturates at 16'hFFFF and clears on rst_i.
- Undefined: no port, no counter logic; all other behaviour is identical.

Decomposition:
- Shared package ppf_pkg holds:
  - constants PPF_NUM_CH=8 and PPF_DATA_W=32, used as parameter defaults here and in ppf_top;
  - enum comm_state_t {SEEK, FILL};
  - function lane_map(idx, reverse).
- No sub-module: the index counter, state machine, fill bank and output register all stay in one module.

Test Plan:
- Alignment and mapping (WAIT_SOF=1, REVERSE_ORDER=1): after reset, feed 3 samples with sof_i=0 (dropped), then 8 samples 0x10..0x17 with sof_i on the first. Expect one data_valid_o pulse one cycle after 0x17, with lane7=0x10 and lane0=0x17.
- Gapped input: the same 8 samples with sample_valid_i toggling every other cycle. Expect identical data_o, a single pulse, and data_o stable afterwards.
- Continuous stream: 32 samples with valid held high and sof_i only on the first. Expect pulses every 8 cycles, 4 blocks, and lane7 of block k = 8k+first-sample value.
- Mid-block sof: sof_i on the 5th sample of a block. Expect sof_err_o pulse, no data_valid_o for the partial block, and the next block to start with that sample. With PPF_COMMUTATOR_DROP_CNT_EN defined, expect drop_cnt_o = 1.
- Reset mid-block: assert rst_i after 4 samples. Expect data_o=0, aligned_o=0 and no pulse. Following samples are dropped until the next sof_i.
- REVERSE_ORDER=0, WAIT_SOF=0: 8 samples 1..8 with no sof_i. Expect lane0=1 and lane7=8.

Source files
------------

// File: rtl/ppf_pkg.sv
// Shared definitions for the polyphase filter bank front end.
// Holds the default lane count and sample width, the commutator state
// encoding, and the lane-mapping helper used by ppf_commutator.
package ppf_pkg;

    localparam int PPF_NUM_CH = 8;
    localparam int PPF_DATA_W = 32;

    typedef enum logic {
        SEEK = 1'b0,
        FILL = 1'b1
    } comm_state_t;

    // Block index to lane: reversed order is the standard PPF commutator,
    // where the oldest sample of a block lands in the highest branch.
    function automatic int unsigned lane_map(input int unsigned idx,
                                             input bit          reverse,
                                             input int unsigned num_ch = PPF_NUM_CH);
        return reverse ? (num_ch - 1 - idx) : idx;
    endfunction

endpackage

// File: rtl/ppf_commutator.sv
// Input commutator for ppf_top: deserialises one sample stream into NUM_CH
// parallel lanes and presents each complete block with a one-cycle
// data_valid_o pulse. A start-of-frame marker realigns the block boundary.
// Optional build macro PPF_COMMUTATOR_DROP_CNT_EN adds a saturating
// drop_cnt_o counter of discarded partial blocks and samples dropped in SEEK.
module ppf_commutator
    import ppf_pkg::*;
#(
    parameter int NUM_CH        = PPF_NUM_CH,
    parameter int DATA_W        = PPF_DATA_W,
    parameter int REVERSE_ORDER = 1,
    parameter int WAIT_SOF      = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     sample_valid_i,
    input  logic [DATA_W-1:0]        sample_i,
    input  logic                     sof_i,
    output logic                     data_valid_o,
    output logic [NUM_CH*DATA_W-1:0] data_o,
    output logic                     sof_err_o,
`ifdef PPF_COMMUTATOR_DROP_CNT_EN
    output logic [15:0]              drop_cnt_o,
`endif
    output logic                     aligned_o
);

    localparam int                   IDX_W    = $clog2(NUM_CH);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(NUM_CH - 1);
    localparam comm_state_t          RST_STATE = (WAIT_SOF != 0) ? SEEK : FILL;

    comm_state_t              state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic signed [DATA_W-1:0] bank_q [NUM_CH];
    logic signed [DATA_W-1:0] bank_d [NUM_CH];
    logic signed [DATA_W-1:0] data_q [NUM_CH];
    logic signed [DATA_W-1:0] data_d [NUM_CH];
    logic                     dvalid_q, dvalid_d;
    logic                     err_q, err_d;
    logic [IDX_W-1:0]         wr_lane;
    logic [IDX_W-1:0]         first_lane;

    // Lane targets for the current index and for block index 0.
    assign wr_lane    = IDX_W'(lane_map(32'(idx_q), REVERSE_ORDER != 0, NUM_CH));
    assign first_lane = IDX_W'(lane_map(32'd0, REVERSE_ORDER != 0, NUM_CH));

    // Next-state logic: alignment FSM, index counter, fill bank and output capture.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        bank_d   = bank_q;
        data_d   = data_q;
        dvalid_d = 1'b0;
        err_d    = 1'b0;
        if (sample_valid_i) begin
            unique case (state_q)
                SEEK: begin
                    if (sof_i) begin
                        bank_d[first_lane] = sample_i;
                        idx_d              = IDX_W'(1);
                        state_d            = FILL;
                    end
                end
                FILL: begin
                    if (sof_i && (idx_q != '0)) begin
                        // Realign: the partial block is abandoned, never presented.
                        bank_d[first_lane] = sample_i;
                        idx_d              = IDX_W'(1);
                        err_d              = 1'b1;
                    end else begin
                        bank_d[wr_lane] = sample_i;
                        if (idx_q == IDX_LAST) begin
                            // Last sample goes straight to the output with the rest of the bank.
                            data_d   = bank_d;
                            dvalid_d = 1'b1;
                            idx_d    = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                default: state_d = RST_STATE;
            endcase
        end
    end

    // State, bank and output registers; reset clears everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= RST_STATE;
            idx_q    <= '0;
            bank_q   <= '{default: '0};
            data_q   <= '{default: '0};
            dvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            bank_q   <= bank_d;
            data_q   <= data_d;
            dvalid_q <= dvalid_d;
            err_q    <= err_d;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_pack
        assign data_o[k*DATA_W +: DATA_W] = data_q[k];
    end

    assign data_valid_o = dvalid_q;
    assign sof_err_o    = err_q;
    assign aligned_o    = (state_q == FILL);

`ifdef PPF_COMMUTATOR_DROP_CNT_EN
    logic        drop_ev;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // A drop event is either a sample discarded while seeking or a partial block abandoned.
    assign drop_ev = sample_valid_i &&
                     (((state_q == SEEK) && !sof_i) ||
                      ((state_q == FILL) && sof_i && (idx_q != '0)));

    // Saturating drop counter.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_ev && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

endmodule
